mmio_stream_port: RTL and testbench

//  Memory-mapped byte-stream peripheral between the CPU data bus (mem_control

---
 rtl/mmio_stream_port_pkg.sv | 46 ++++
 rtl/mmio_stream_port_sync_fifo.sv | 67 ++++++
 rtl/mmio_stream_port.sv | 148 ++++++++++++++
 tb/tb_mmio_stream_port.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_stream_port_pkg.sv
// mmio_stream_port_pkg
//   Register indices, STATUS/CTRL bit positions and a STATUS packing helper.
//   Firmware headers carry the same values, so these numbers are frozen.
package mmio_stream_port_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_idx_e;

  localparam int unsigned STATUS_RX_NEMPTY  = 0;
  localparam int unsigned STATUS_TX_FULL    = 1;
  localparam int unsigned STATUS_TX_EMPTY   = 2;
  localparam int unsigned STATUS_TXDROP     = 3;
  localparam int unsigned STATUS_RX_CNT_LSB = 8;
  localparam int unsigned STATUS_TX_CNT_LSB = 16;
  localparam int unsigned STATUS_CNT_W      = 5;

  localparam int unsigned CTRL_RX_IRQ = 0;
  localparam int unsigned CTRL_TX_IRQ = 1;
  localparam int unsigned CTRL_W      = 2;

  localparam int unsigned DATA_VALID_BIT = 8;

  function automatic logic [31:0] pack_status(
    input logic                    rx_nempty,
    input logic                    tx_full,
    input logic                    tx_empty,
    input logic                    txdrop,
    input logic [STATUS_CNT_W-1:0] rx_cnt,
    input logic [STATUS_CNT_W-1:0] tx_cnt
  );
    logic [31:0] w;
    w = '0;
    w[STATUS_RX_NEMPTY] = rx_nempty;
    w[STATUS_TX_FULL]   = tx_full;
    w[STATUS_TX_EMPTY]  = tx_empty;
    w[STATUS_TXDROP]    = txdrop;
    w[STATUS_RX_CNT_LSB +: STATUS_CNT_W] = rx_cnt;
    w[STATUS_TX_CNT_LSB +: STATUS_CNT_W] = tx_cnt;
    return w;
  endfunction

endpackage

// File: rtl/mmio_stream_port_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with occupancy count. Push and pop in the same cycle
//   are legal at every fill level: on a full FIFO the pop frees the slot the
//   push uses; on an empty FIFO the pop is ignored and the push lands.
// Ports
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   push, din      write request and data
//   pop            read request (ignored when empty)
//   dout           head entry, 0 while empty
//   full, empty    occupancy flags
//   count          number of stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = cnt;

  // Masked so the output is a clean 0 after reset without resetting storage.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so natural pointer overflow is the wrap.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mmio_stream_port.sv
// mmio_stream_port
//   Memory-mapped byte stream between the CPU data bus and the USB_CDC
//   stream handshake. RX FIFO holds host->CPU bytes, TX FIFO holds
//   CPU->host bytes. Registers: DATA (0), STATUS (1), CTRL (2), reserved (3).
//   Depths up to 16 fit the 5-bit STATUS count fields.
// Ports
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   sel_i, read_i, write_i        bus select and strobes (write wins)
//   addr_i, wdata_i               word register index, write data
//   rdata_o, rvalid_o             registered read data and its one-cycle valid
//   irq_o                         registered level interrupt
//   in_data_o/in_valid_o/in_ready_i     TX stream toward USB_CDC
//   out_data_i/out_valid_i/out_ready_o  RX stream from USB_CDC
module mmio_stream_port
  import mmio_stream_port_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        sel_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        irq_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o
);

  localparam int unsigned RCW = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TCW = $clog2(TX_DEPTH) + 1;

  logic rd_acc;
  logic wr_acc;

  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]     rx_dout;
  logic [RCW-1:0] rx_count, rx_cnt_nxt;

  logic           tx_push, tx_pop, tx_full, tx_empty, tx_wr;
  logic [7:0]     tx_dout;
  logic [TCW-1:0] tx_count, tx_cnt_nxt;

  logic              txdrop_q, txdrop_d;
  logic              txdrop_set, txdrop_clr;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       rd_word;
  logic              irq_d;

  assign wr_acc = sel_i & write_i;
  assign rd_acc = sel_i & read_i & ~write_i;

  // RX: a full FIFO still takes the incoming byte when a DATA read frees a
  // slot in the same cycle, even though out_ready_o is low that cycle.
  assign out_ready_o = ~rx_full;
  assign rx_pop      = rd_acc & (addr_i == REG_DATA) & ~rx_empty;
  assign rx_push     = out_valid_i & (~rx_full | rx_pop);

  // TX: a write into a full FIFO survives only if the head leaves this cycle.
  assign in_valid_o = ~tx_empty;
  assign in_data_o  = tx_dout;
  assign tx_pop     = in_valid_o & in_ready_i;
  assign tx_wr      = wr_acc & (addr_i == REG_DATA);
  assign tx_push    = tx_wr & (~tx_full | tx_pop);

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (rx_push),
    .pop    (rx_pop),
    .din    (out_data_i),
    .dout   (rx_dout),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (tx_push),
    .pop    (tx_pop),
    .din    (wdata_i[7:0]),
    .dout   (tx_dout),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  // Set dominates clear.
  assign txdrop_set = tx_wr & tx_full & ~tx_pop;
  assign txdrop_clr = wr_acc & (addr_i == REG_STATUS) & wdata_i[STATUS_TXDROP];
  assign txdrop_d   = txdrop_set | (txdrop_q & ~txdrop_clr);

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_acc && addr_i == REG_CTRL) ctrl_d = wdata_i[CTRL_W-1:0];
  end

  always_comb begin
    rd_word = '0;
    case (addr_i)
      REG_DATA: begin
        if (!rx_empty) begin
          rd_word[DATA_VALID_BIT] = 1'b1;
          rd_word[7:0]            = rx_dout;
        end
      end
      REG_STATUS: rd_word = pack_status(~rx_empty, tx_full, tx_empty, txdrop_q,
                                        STATUS_CNT_W'(rx_count),
                                        STATUS_CNT_W'(tx_count));
      REG_CTRL:   rd_word[CTRL_W-1:0] = ctrl_q;
      default:    rd_word = '0;
    endcase
  end

  // irq is built from post-edge occupancy and CTRL so the registered output
  // tracks the current state with no extra cycle of lag.
  assign rx_cnt_nxt = rx_count + RCW'(rx_push) - RCW'(rx_pop);
  assign tx_cnt_nxt = tx_count + TCW'(tx_push) - TCW'(tx_pop);
  assign irq_d = (ctrl_d[CTRL_RX_IRQ] & (rx_cnt_nxt != '0)) |
                 (ctrl_d[CTRL_TX_IRQ] & (tx_cnt_nxt == '0));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      txdrop_q <= 1'b0;
      ctrl_q   <= '0;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      txdrop_q <= txdrop_d;
      ctrl_q   <= ctrl_d;
      rvalid_o <= rd_acc;
      rdata_o  <= rd_acc ? rd_word : '0;
      irq_o    <= irq_d;
    end
  end

endmodule

// File: tb/tb_mmio_stream_port.sv
module tb_mmio_stream_port;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        sel_i, read_i, write_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        irq_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;
  logic [7:0]  out_data_i;
  logic        out_valid_i;
  logic        out_ready_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] exp_rd;
  logic [7:0]  exp_tx;

  always #5 clk_i = ~clk_i;

  mmio_stream_port #(.RX_DEPTH(16), .TX_DEPTH(16)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .sel_i       (sel_i),
    .read_i      (read_i),
    .write_i     (write_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .irq_o       (irq_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: read responses and TX handshakes, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rstn_i === 1'b1) begin
      if (rvalid_o) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rvalid: got rdata 0x%08h expected no response", rdata_o);
        end else begin
          exp_rd = rd_q.pop_front();
          chk("rdata", rdata_o, exp_rd);
        end
      end else begin
        chk("rdata_idle_zero", rdata_o, 32'h0);
      end
      if (in_valid_o && in_ready_i) begin
        if (tx_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_tx: got byte 0x%02h expected none", in_data_o);
        end else begin
          exp_tx = tx_q.pop_front();
          chk("tx_byte", {24'h0, in_data_o}, {24'h0, exp_tx});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel_i = 1'b1; write_i = 1'b1; addr_i = a; wdata_i = d;
    tick();
    sel_i = 1'b0; write_i = 1'b0; wdata_i = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] e);
    rd_q.push_back(e);
    sel_i = 1'b1; read_i = 1'b1; addr_i = a;
    tick();
    sel_i = 1'b0; read_i = 1'b0;
  endtask

  task automatic tx_drain(input int budget);
    in_ready_i = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!in_valid_o) break;
      tick();
    end
    in_ready_i = 1'b0;
    chk("tx_drained_valid", {31'h0, in_valid_o}, 32'h0);
    chk("tx_queue_empty", tx_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0; sel_i = 0; read_i = 0; write_i = 0; addr_i = 0; wdata_i = 0;
    in_ready_i = 0; out_data_i = 0; out_valid_i = 0;
    #3;
    chk("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_in_valid", {31'h0, in_valid_o}, 32'h0);
    chk("rst_in_data", {24'h0, in_data_o}, 32'h0);
    chk("rst_out_ready", {31'h0, out_ready_o}, 32'h1);
    tick(); tick();
    rstn_i = 1'b1;
    tick();

    // 1: STATUS after reset
    bus_read(2'd1, 32'h0000_0004);
    chk("t1_out_ready", {31'h0, out_ready_o}, 32'h1);
    chk("t1_in_valid", {31'h0, in_valid_o}, 32'h0);

    // 2: TX bytes held, then delivered in order
    tx_q.push_back(8'h41); bus_write(2'd0, 32'h41);
    tx_q.push_back(8'h42); bus_write(2'd0, 32'h42);
    chk("t2_in_valid", {31'h0, in_valid_o}, 32'h1);
    chk("t2_in_data", {24'h0, in_data_o}, 32'h41);
    bus_read(2'd1, 32'h0002_0000);
    tx_drain(10);

    // 3: RX fill, back-pressure, read+push in the same cycle
    out_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      out_data_i = 8'h60 + 8'(i);
      tick();
    end
    out_data_i = 8'h70;
    tick();
    chk("t3_out_ready_full", {31'h0, out_ready_o}, 32'h0);
    bus_read(2'd1, 32'h0000_1005);
    bus_read(2'd0, 32'h0000_0160);
    out_valid_i = 1'b0;
    bus_read(2'd1, 32'h0000_1005);
    for (int i = 1; i < 16; i++) bus_read(2'd0, 32'h0000_0160 + 32'(i));
    bus_read(2'd0, 32'h0000_0170);
    bus_read(2'd0, 32'h0000_0000);
    chk("t3_out_ready_empty", {31'h0, out_ready_o}, 32'h1);

    // 4: TX overflow drop, sticky clear, full write with concurrent pop
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'h80 + 8'(i));
      bus_write(2'd0, 32'h80 + 32'(i));
    end
    bus_read(2'd1, 32'h0010_0002);
    bus_write(2'd0, 32'h55);
    bus_read(2'd1, 32'h0010_000A);
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, 32'h0010_0002);
    in_ready_i = 1'b1;
    tx_q.push_back(8'h99);
    bus_write(2'd0, 32'h99);
    in_ready_i = 1'b0;
    bus_read(2'd1, 32'h0010_0002);
    tx_drain(40);

    // 5: interrupts
    bus_write(2'd2, 32'h1);
    chk("t5_irq_rx_empty", {31'h0, irq_o}, 32'h0);
    out_data_i = 8'h33; out_valid_i = 1'b1;
    tick();
    out_valid_i = 1'b0;
    chk("t5_irq_rx_data", {31'h0, irq_o}, 32'h1);
    bus_read(2'd0, 32'h0000_0133);
    chk("t5_irq_after_pop", {31'h0, irq_o}, 32'h0);
    bus_read(2'd2, 32'h0000_0001);
    bus_write(2'd2, 32'h2);
    chk("t5_irq_tx_empty", {31'h0, irq_o}, 32'h1);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, 32'h0000_0000);
    bus_read(2'd2, 32'h0000_0002);

    // 6: reset mid-operation
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 8; i++) bus_write(2'd0, 32'hA0 + 32'(i));
    out_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      out_data_i = 8'hB0 + 8'(i);
      tick();
    end
    out_valid_i = 1'b0;
    chk("t6_irq_before_rst", {31'h0, irq_o}, 32'h1);
    tick(); tick();
    tx_q.delete();
    rstn_i = 1'b0;
    #1;
    chk("t6_rst_in_valid", {31'h0, in_valid_o}, 32'h0);
    chk("t6_rst_in_data", {24'h0, in_data_o}, 32'h0);
    chk("t6_rst_out_ready", {31'h0, out_ready_o}, 32'h1);
    chk("t6_rst_irq", {31'h0, irq_o}, 32'h0);
    chk("t6_rst_rvalid", {31'h0, rvalid_o}, 32'h0);
    tick();
    rstn_i = 1'b1;
    tick();
    bus_read(2'd1, 32'h0000_0004);
    bus_read(2'd0, 32'h0000_0000);
    bus_read(2'd2, 32'h0000_0000);
    chk("t6_in_valid_after", {31'h0, in_valid_o}, 32'h0);

    tick(); tick();
    chk("rd_queue_empty", rd_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
